// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: two-to-one AXI read-channel arbiter (icache = m0, dcache = m1)
// in front of one memory slave. Round-robin on ties, one outstanding transaction,
// and each returning burst is routed back to the master that issued it.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   m0_ar*/m0_r*, m1_ar*/m1_r*  per-master AR request and R response channels
//   s_ar*/s_r*                 shared slave AR request and R response channels
//   grant                      index of the current or most recent owner
//   busy                       high while a transaction is in ADDR or DATA
module mem_read_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [LEN_WIDTH-1:0]  m0_arlen,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rlast,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,

    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [LEN_WIDTH-1:0]  m1_arlen,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rlast,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,

    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic [LEN_WIDTH-1:0]  s_arlen,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rlast,
    input  logic                  s_rvalid,
    output logic                  s_rready,

    output logic                  grant,
    output logic                  busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       grant_nxt;
    logic       last_grant;
    logic       last_grant_nxt;

    // State, owner and round-robin history; last_grant resets to 1 so the first tie goes to m0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next-state logic and combinational channel routing to/from the owner.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;

        busy       = 1'b0;
        s_araddr   = '0;
        s_arlen    = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m0_rlast   = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        m1_rlast   = 1'b0;
        m1_rvalid  = 1'b0;

        case (state)
            IDLE: begin
                if (m0_arvalid || m1_arvalid) begin
                    state_nxt = ADDR;
                    if (m0_arvalid && m1_arvalid) begin
                        grant_nxt = ~last_grant;
                    end else begin
                        grant_nxt = m1_arvalid;
                    end
                end
            end

            ADDR: begin
                busy = 1'b1;
                if (grant) begin
                    s_araddr   = m1_araddr;
                    s_arlen    = m1_arlen;
                    s_arvalid  = m1_arvalid;
                    m1_arready = s_arready;
                end else begin
                    s_araddr   = m0_araddr;
                    s_arlen    = m0_arlen;
                    s_arvalid  = m0_arvalid;
                    m0_arready = s_arready;
                end
                if (s_arvalid && s_arready) begin
                    state_nxt      = DATA;
                    last_grant_nxt = grant;
                end
            end

            DATA: begin
                busy = 1'b1;
                if (grant) begin
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rlast  = s_rlast;
                    m1_rvalid = s_rvalid;
                    s_rready  = m1_rready;
                end else begin
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rlast  = s_rlast;
                    m0_rvalid = s_rvalid;
                    s_rready  = m0_rready;
                end
                // Only rlast ends the burst; beat count is not tracked.
                if (s_rvalid && s_rready && s_rlast) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed requests, a small slave model returning
// data = address + beat index and rresp = address[13:12], and a scoreboard
// monitor checking every accepted R beat against the expected queue.
module tb_mem_read_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] m0_araddr, m1_araddr, s_araddr;
    logic [7:0]  m0_arlen, m1_arlen, s_arlen;
    logic        m0_arvalid, m1_arvalid, s_arvalid;
    logic        m0_arready, m1_arready, s_arready;
    logic [31:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]  m0_rresp, m1_rresp, s_rresp;
    logic        m0_rlast, m1_rlast, s_rlast;
    logic        m0_rvalid, m1_rvalid, s_rvalid;
    logic        m0_rready, m1_rready, s_rready;
    logic        grant, busy;

    mem_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          m;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_burst(input int m, input logic [31:0] addr, input int len);
        for (int i = 0; i <= len; i++) begin
            sb.push_back('{m, addr + 32'(i), addr[13:12], (i == len)});
        end
    endtask

    task automatic set_req(input int m, input logic [31:0] addr, input logic [7:0] len);
        if (m == 0) begin
            m0_araddr = addr; m0_arlen = len; m0_arvalid = 1'b1;
        end else begin
            m1_araddr = addr; m1_arlen = len; m1_arvalid = 1'b1;
        end
    endtask

    // Waits for master m's AR handshake, returns the cycle index it happened on, then drops arvalid.
    task automatic wait_ar(input int m, output int n);
        logic hs;
        n = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            hs = (m == 0) ? (m0_arvalid && m0_arready) : (m1_arvalid && m1_arready);
            if (hs) begin
                n = i;
                chk("ar_grant", 64'(grant), 64'(m));
                chk("ar_other_ready", 64'((m == 0) ? m1_arready : m0_arready), 64'd0);
                chk("ar_addr", 64'(s_araddr), 64'((m == 0) ? m0_araddr : m1_araddr));
                break;
            end
        end
        if (n < 0) begin
            checks++;
            errors++;
            $display("FAIL ar_timeout: master %0d never got arready", m);
        end
        @(posedge clk); #1;
        if (m == 0) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
    endtask

    // Waits until all expected beats are consumed and the arbiter is back in IDLE.
    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: busy=%0d pending=%0d", busy, sb.size());
        end
        @(posedge clk); #1;
    endtask

    // Slave model: accepts one AR, then streams len+1 beats with rvalid held high.
    logic        sl_active;
    logic [31:0] sl_addr;
    logic [7:0]  sl_len;
    logic [7:0]  sl_beat;
    initial begin
        logic        ar_hs, r_hs;
        logic [31:0] cap_addr;
        logic [7:0]  cap_len;
        sl_active = 1'b0; sl_addr = '0; sl_len = '0; sl_beat = '0;
        s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rlast = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs    = s_arvalid && s_arready;
            r_hs     = s_rvalid && s_rready;
            cap_addr = s_araddr;
            cap_len  = s_arlen;
            @(posedge clk); #1;
            if (!rst_n) begin
                sl_active = 1'b0;
            end else begin
                if (r_hs) begin
                    if (sl_beat == sl_len) sl_active = 1'b0;
                    else sl_beat = sl_beat + 8'd1;
                end
                if (ar_hs) begin
                    sl_active = 1'b1; sl_addr = cap_addr; sl_len = cap_len; sl_beat = '0;
                end
            end
            s_rvalid = sl_active;
            s_rdata  = sl_active ? sl_addr + 32'(sl_beat) : 32'd0;
            s_rresp  = sl_active ? sl_addr[13:12] : 2'b00;
            s_rlast  = sl_active && (sl_beat == sl_len);
        end
    end

    // Scoreboard monitor: every accepted beat on either master is popped and compared.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int m = 0; m < 2; m++) begin
                    logic        acc;
                    logic [31:0] d;
                    logic [1:0]  r;
                    logic        l;
                    logic        other_v;
                    acc     = (m == 0) ? (m0_rvalid && m0_rready) : (m1_rvalid && m1_rready);
                    d       = (m == 0) ? m0_rdata : m1_rdata;
                    r       = (m == 0) ? m0_rresp : m1_rresp;
                    l       = (m == 0) ? m0_rlast : m1_rlast;
                    other_v = (m == 0) ? m1_rvalid : m0_rvalid;
                    if (acc) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat: master %0d data 0x%0h with empty queue", m, d);
                        end else begin
                            e = sb.pop_front();
                            chk("beat_master", 64'(m), 64'(e.m));
                            chk("beat_data", 64'(d), 64'(e.data));
                            chk("beat_resp", 64'(r), 64'(e.resp));
                            chk("beat_last", 64'(l), 64'(e.last));
                            chk("beat_other_rvalid", 64'(other_v), 64'd0);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        logic got;
        rst_n = 1'b0;
        m0_araddr = '0; m0_arlen = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
        m1_araddr = '0; m1_arlen = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
        s_arready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
        chk("rst_arready", 64'({m0_arready, m1_arready}), 64'd0);
        chk("rst_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'd0);
        chk("rst_s_rready", 64'(s_rready), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // First tie after reset: m0 first, m1 after a single IDLE cycle
        set_req(0, 32'h200, 8'd0);
        set_req(1, 32'h300, 8'd0);
        push_burst(0, 32'h200, 0);
        push_burst(1, 32'h300, 0);
        wait_ar(0, n);
        chk("tie1_latency", 64'(n), 64'd1);
        wait_ar(1, n);
        chk("tie1_turnaround", 64'(n), 64'd2);
        drain();

        // Single m0 burst of 4 beats
        set_req(0, 32'h100, 8'd3);
        push_burst(0, 32'h100, 3);
        @(negedge clk);
        chk("arb_latency_idle", 64'(s_arvalid), 64'd0);
        wait_ar(0, n);
        chk("arb_latency", 64'(n), 64'd0);
        drain();
        chk("single_grant", 64'(grant), 64'd0);

        // Tie with last_grant = 0: m1 wins
        set_req(0, 32'h240, 8'd0);
        set_req(1, 32'h340, 8'd0);
        push_burst(1, 32'h340, 0);
        push_burst(0, 32'h240, 0);
        wait_ar(1, n);
        wait_ar(0, n);
        drain();

        // Slave stalls arready for 5 cycles in ADDR
        s_arready = 1'b0;
        set_req(1, 32'h400, 8'd1);
        push_burst(1, 32'h400, 1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_arready", 64'(m1_arready), 64'd0);
            chk("stall_addr", 64'(s_araddr), 64'h400);
            chk("stall_busy_valid", 64'({busy, s_arvalid, s_rready}), 64'b110);
        end
        @(posedge clk); #1 s_arready = 1'b1;
        wait_ar(1, n);
        chk("stall_release", 64'(n), 64'd0);
        drain();

        // m1 8-beat burst with toggling rready; m0 requests during DATA (error response)
        set_req(1, 32'h500, 8'd7);
        push_burst(1, 32'h500, 7);
        push_burst(0, 32'h2600, 1);
        wait_ar(1, n);
        set_req(0, 32'h2600, 8'd1);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m0_arvalid && m0_arready) begin
                got = 1'b1;
                chk("m0_after_m1_grant", 64'(grant), 64'd0);
                break;
            end
            if (grant && busy) begin
                chk("held_off_arready", 64'(m0_arready), 64'd0);
                chk("rready_mirror", 64'(s_rready), 64'(m1_rready));
            end
            @(posedge clk); #1 m1_rready = ~m1_rready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL m0_after_m1: m0 never granted");
        end
        @(posedge clk); #1;
        m0_arvalid = 1'b0;
        m1_rready  = 1'b1;
        drain();

        // Reset mid-burst, then a fresh m1 request
        set_req(1, 32'h700, 8'd7);
        push_burst(1, 32'h700, 7);
        wait_ar(1, n);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_grant", 64'(grant), 64'd0);
        chk("midrst_valids", 64'({s_arvalid, m0_rvalid, m1_rvalid, s_rready}), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        set_req(1, 32'h800, 8'd1);
        push_burst(1, 32'h800, 1);
        wait_ar(1, n);
        chk("post_rst_latency", 64'(n), 64'd1);
        drain();
        chk("post_rst_grant", 64'(grant), 64'd1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
